// File: rtl/psum_drain.sv
// Column drain: accumulates K passes of partial sums per row, then requantizes
// each row to int8 and streams it out over a valid/ready port.
module psum_drain #(
  parameter int OW    = 19,
  parameter int AW    = 24,
  parameter int DEPTH = 16,
  parameter int RW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RW:0]       num_row,
  input  logic [3:0]        num_pass,
  input  logic [4:0]        shift,
  input  logic              psum_vld,
  input  logic [OW-1:0]     psum,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  localparam logic [RW:0]        ROW_ONE = 1;
  localparam logic signed [AW:0] MAXV    = 127;
  localparam logic signed [AW:0] MINV    = -128;

  state_t state, state_nx;

  logic signed [AW-1:0] acc [DEPTH];
  logic [RW:0]          row_cnt, num_row_q;
  logic [3:0]           pass_cnt, num_pass_q;
  logic [4:0]           shift_q;

  logic [RW-1:0]        idx;
  logic signed [AW-1:0] psum_ext, acc_rd;
  logic                 sample, last_row, last_pass, xfer, load;
  logic signed [AW:0]   ext, rnd, sum, r;
  logic [7:0]           q;

  always_comb begin
    idx       = row_cnt[RW-1:0];
    psum_ext  = AW'(signed'(psum));
    acc_rd    = acc[idx];
    sample    = (state == ACC) && psum_vld;
    last_row  = (row_cnt == num_row_q - ROW_ONE);
    last_pass = (pass_cnt == num_pass_q - 4'd1);
    xfer      = out_vld && out_rdy;
    load      = (state == EMIT) && (row_cnt < num_row_q) && (!out_vld || out_rdy);
  end

  // Round-half-up then arithmetic shift, one bit wider so the bias cannot overflow.
  always_comb begin
    ext = (AW+1)'(acc_rd);
    rnd = (shift_q == 5'd0) ? '0 : ((AW+1)'(1) << (shift_q - 5'd1));
    sum = ext + rnd;
    r   = sum >>> shift_q;
    if (r > MAXV)      q = 8'h7F;
    else if (r < MINV) q = 8'h80;
    else               q = r[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACC;
      ACC:     if (sample && last_row && last_pass) state_nx = EMIT;
      EMIT:    if (xfer && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Array read is combinational, so a write at one edge is visible to the
  // next cycle's read-modify-write even when num_row is 1.
  always_ff @(posedge clk) begin
    if (sample) acc[idx] <= (pass_cnt == 4'd0) ? psum_ext : acc_rd + psum_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt    <= '0;
      pass_cnt   <= '0;
      num_row_q  <= ROW_ONE;
      num_pass_q <= 4'd1;
      shift_q    <= '0;
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= (state == EMIT) && xfer && out_last;
      if (psum_vld && state != ACC)  err <= 1'b1;
      else if (state == IDLE && start) err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          num_row_q  <= (num_row == '0) ? ROW_ONE : num_row;
          num_pass_q <= (num_pass == 4'd0) ? 4'd1 : num_pass;
          shift_q    <= shift;
          row_cnt    <= '0;
          pass_cnt   <= '0;
        end
        ACC: if (sample) begin
          if (last_row) begin
            row_cnt  <= '0;
            pass_cnt <= pass_cnt + 4'd1;
          end else begin
            row_cnt  <= row_cnt + ROW_ONE;
          end
        end
        EMIT: begin
          if (load) begin
            out_data <= q;
            out_last <= last_row;
            out_vld  <= 1'b1;
            row_cnt  <= row_cnt + ROW_ONE;
          end else if (xfer) begin
            out_vld  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: timing, requantization, backpressure,
// protocol errors and reset recovery against hand-computed results.
module tb_psum_drain;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [4:0]        num_row;
  logic [3:0]        num_pass;
  logic [4:0]        shift;
  logic              psum_vld;
  logic [18:0]       psum;
  logic              out_vld;
  logic              out_rdy;
  logic [7:0]        out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  psum_drain #(.OW(19), .AW(24), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_row(num_row),
    .num_pass(num_pass), .shift(shift), .psum_vld(psum_vld), .psum(psum),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic job(input logic [4:0] nr, input logic [3:0] np, input logic [4:0] sh);
    start = 1'b1; num_row = nr; num_pass = np; shift = sh;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int v);
    psum_vld = 1'b1;
    psum = 19'(v);
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; num_row = '0; num_pass = '0; shift = '0;
    psum_vld = 1'b0; psum = '0; out_rdy = 1'b1;
    #1;
    total++;
    if ({out_vld, out_data, out_last, busy, done, err} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", {out_vld, out_data, out_last, busy, done, err}, 13'b0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int v [6] = '{10, -5, 20, -5, 30, -5};
    job(5'd2, 4'd3, 5'd0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
    for (int i = 0; i < 6; i++) feed(v[i]);
    psum_vld = 1'b0;
    total++;
    if ({busy, out_vld} !== 2'b10) begin bad++; $display("FAIL basic_emit_entry got=%b exp=10", {busy, out_vld}); end
    tick();
    total++;
    if ({out_vld, out_last, out_data} !== {2'b10, 8'h3C}) begin
      bad++; $display("FAIL basic_row0 got=%h exp=%h", {out_vld, out_last, out_data}, {2'b10, 8'h3C});
    end
    tick();
    total++;
    if ({out_vld, out_last, out_data} !== {2'b11, 8'hF1}) begin
      bad++; $display("FAIL basic_row1 got=%h exp=%h", {out_vld, out_last, out_data}, {2'b11, 8'hF1});
    end
    tick();
    total++;
    if ({out_vld, done, busy} !== 3'b010) begin bad++; $display("FAIL basic_done got=%b exp=010", {out_vld, done, busy}); end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_rounding;
    int          v [4]   = '{6, -6, 1000, -1000};
    logic [7:0]  exp [4] = '{8'h02, 8'hFF, 8'h7F, 8'h80};
    job(5'd4, 4'd1, 5'd2);
    for (int i = 0; i < 4; i++) feed(v[i]);
    psum_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({out_vld, out_last, out_data} !== {1'b1, (i == 3), exp[i]}) begin
        bad++;
        $display("FAIL round_row%0d got=%h exp=%h", i, {out_vld, out_last, out_data}, {1'b1, (i == 3), exp[i]});
      end
    end
    tick();
    total++;
    if ({out_vld, done} !== 2'b01) begin bad++; $display("FAIL round_done got=%b exp=01", {out_vld, done}); end
  endtask

  task automatic test_backpressure;
    int v [6] = '{10, -5, 20, -5, 30, -5};
    out_rdy = 1'b0;
    job(5'd2, 4'd3, 5'd0);
    for (int i = 0; i < 6; i++) feed(v[i]);
    psum_vld = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_vld, out_last, out_data} !== {2'b10, 8'h3C}) begin
        bad++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {out_vld, out_last, out_data}, {2'b10, 8'h3C});
      end
      tick();
    end
    out_rdy = 1'b1;
    total++;
    if ({out_vld, out_data} !== {1'b1, 8'h3C}) begin
      bad++; $display("FAIL bp_release got=%h exp=%h", {out_vld, out_data}, {1'b1, 8'h3C});
    end
    tick();
    total++;
    if ({out_vld, out_last, out_data} !== {2'b11, 8'hF1}) begin
      bad++; $display("FAIL bp_row1 got=%h exp=%h", {out_vld, out_last, out_data}, {2'b11, 8'hF1});
    end
    tick();
    total++;
    if ({out_vld, done, busy} !== 3'b010) begin bad++; $display("FAIL bp_done got=%b exp=010", {out_vld, done, busy}); end
  endtask

  task automatic test_single_row;
    job(5'd1, 4'd15, 5'd16);
    for (int i = 0; i < 15; i++) feed(262143);
    psum_vld = 1'b0;
    tick();
    total++;
    if ({out_vld, out_last, out_data} !== {2'b11, 8'h3C}) begin
      bad++; $display("FAIL single_row got=%h exp=%h", {out_vld, out_last, out_data}, {2'b11, 8'h3C});
    end
    tick();
    total++;
    if ({done, busy} !== 2'b10) begin bad++; $display("FAIL single_done got=%b exp=10", {done, busy}); end
  endtask

  task automatic test_errors;
    psum_vld = 1'b1; psum = 19'd3;
    tick();
    psum_vld = 1'b0;
    total++;
    if ({err, busy} !== 2'b10) begin bad++; $display("FAIL err_idle got=%b exp=10", {err, busy}); end
    job(5'd1, 4'd1, 5'd0);
    total++;
    if ({err, busy} !== 2'b01) begin bad++; $display("FAIL err_clear got=%b exp=01", {err, busy}); end
    job(5'd4, 4'd3, 5'd0);
    total++;
    if ({err, busy} !== 2'b01) begin bad++; $display("FAIL start_in_acc got=%b exp=01", {err, busy}); end
    feed(5);
    psum = 19'd0;
    tick();
    psum_vld = 1'b0;
    total++;
    if ({out_vld, out_last, out_data, err} !== {2'b11, 8'h05, 1'b1}) begin
      bad++; $display("FAIL err_emit got=%h exp=%h", {out_vld, out_last, out_data, err}, {2'b11, 8'h05, 1'b1});
    end
    tick();
    total++;
    if ({done, err} !== 2'b11) begin bad++; $display("FAIL err_sticky got=%b exp=11", {done, err}); end
    job(5'd1, 4'd1, 5'd0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_restart got=%b exp=0", err); end
    feed(7);
    psum_vld = 1'b0;
    tick();
    total++;
    if ({out_vld, out_data} !== {1'b1, 8'h07}) begin
      bad++; $display("FAIL err_recover got=%h exp=%h", {out_vld, out_data}, {1'b1, 8'h07});
    end
    tick();
  endtask

  task automatic test_reset_mid_emit;
    out_rdy = 1'b0;
    job(5'd2, 4'd1, 5'd0);
    feed(3); feed(4);
    psum_vld = 1'b0;
    tick();
    total++;
    if ({out_vld, out_data} !== {1'b1, 8'h03}) begin
      bad++; $display("FAIL rst_pre got=%h exp=%h", {out_vld, out_data}, {1'b1, 8'h03});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_vld, out_data, out_last, busy, done, err} !== 13'b0) begin
      bad++; $display("FAIL rst_mid_emit got=%b exp=%b", {out_vld, out_data, out_last, busy, done, err}, 13'b0);
    end
    tick();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    tick();
    job(5'd2, 4'd1, 5'd0);
    feed(9); feed(-9);
    psum_vld = 1'b0;
    tick();
    total++;
    if ({out_vld, out_last, out_data} !== {2'b10, 8'h09}) begin
      bad++; $display("FAIL rst_after_row0 got=%h exp=%h", {out_vld, out_last, out_data}, {2'b10, 8'h09});
    end
    tick();
    total++;
    if ({out_vld, out_last, out_data} !== {2'b11, 8'hF7}) begin
      bad++; $display("FAIL rst_after_row1 got=%h exp=%h", {out_vld, out_last, out_data}, {2'b11, 8'hF7});
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_single_row();
    test_errors();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
